// File: rtl/dcache_pkg.sv
// Shared types and constants for the DCache AXI write path.
package dcache_pkg;

  localparam int unsigned PADDR_SIZE = 32;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned AXI_ID_W   = 6;

  // Base AXI ID owned by the DCache; the uncached source takes the next one.
  localparam logic [AXI_ID_W-1:0] DCACHE_ID = 6'd2;

  typedef struct packed {
    logic [PADDR_SIZE-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [AXI_ID_W-1:0]   id;
  } AxiAwReq;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] wstrb;
    logic              last;
  } AxiWBeat;

  typedef enum logic {
    SRC_REP = 1'b0,
    SRC_UNC = 1'b1
  } src_e;

endpackage

// File: rtl/dcache_write_arbiter_w_order_fifo.sv
// Records which source owns each granted AW so W beats are steered in grant order.
module dcache_write_arbiter_w_order_fifo
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  src_e push_src,
  input  logic pop,
  output logic full,
  output logic empty,
  output src_e head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  // Pointers carry an extra direction bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  src_e        mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  // Fullness is judged before a same-cycle pop; a pop never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push/pop; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage write; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_src;
  end

endmodule

// File: rtl/dcache_write_arbiter.sv
// Arbitrates the DCache AXI write channel between the replace and uncached sources.
module dcache_write_arbiter
  import dcache_pkg::*;
#(
  parameter int unsigned         ORDER_DEPTH     = 4,
  parameter int unsigned         MAX_OUTSTANDING = 4,
  parameter logic [AXI_ID_W-1:0] REP_ID          = DCACHE_ID,
  parameter logic [AXI_ID_W-1:0] UNC_ID          = REP_ID + AXI_ID_W'(1)
) (
  input  logic                clk,
  input  logic                rst,
  // replace (line writeback) source
  input  logic                rep_aw_valid,
  output logic                rep_aw_ready,
  input  AxiAwReq             rep_aw,
  input  logic                rep_w_valid,
  output logic                rep_w_ready,
  input  AxiWBeat             rep_w,
  output logic                rep_b_valid,
  input  logic                rep_b_ready,
  output logic [1:0]          rep_b_resp,
  input  logic                rep_urgent,
  // uncached / MMIO store source
  input  logic                unc_aw_valid,
  output logic                unc_aw_ready,
  input  AxiAwReq             unc_aw,
  input  logic                unc_w_valid,
  output logic                unc_w_ready,
  input  AxiWBeat             unc_w,
  output logic                unc_b_valid,
  input  logic                unc_b_ready,
  output logic [1:0]          unc_b_resp,
  // downstream AXI master
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output AxiAwReq             m_aw,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output AxiWBeat             m_w,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [AXI_ID_W-1:0] m_b_id,
  input  logic [1:0]          m_b_resp,
  // status
  output logic                idle,
  output logic                id_err
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW:0] MaxOut = MAX_OUTSTANDING[CntW:0];
  localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

  logic            slot_valid_q;
  AxiAwReq         slot_q;
  logic [CntW-1:0] out_cnt_q;
  src_e            rr_q;
  logic            id_err_q;

  logic    fifo_full;
  logic    fifo_empty;
  src_e    fifo_head;
  logic    fifo_pop;

  logic        aw_hs;
  logic        b_hs;
  logic [CntW:0] pending;
  logic        load_ok;
  logic        grant_rep;
  logic        grant_unc;
  logic        load;
  AxiAwReq     grant_aw;
  logic        id_unknown;

  // ---------------- AW stage ----------------
  assign aw_hs   = slot_valid_q && m_aw_ready;
  // Writes already downstream plus the one parked in the slot count against the limit.
  assign pending = {1'b0, out_cnt_q} + {{CntW{1'b0}}, slot_valid_q};
  assign load_ok = !rst && (!slot_valid_q || aw_hs) && !fifo_full && (pending < MaxOut);

  assign grant_rep = rep_aw_valid && (!unc_aw_valid || rep_urgent || (rr_q == SRC_REP));
  assign grant_unc = unc_aw_valid && !grant_rep;
  assign load      = load_ok && (grant_rep || grant_unc);

  assign rep_aw_ready = load_ok && grant_rep;
  assign unc_aw_ready = load_ok && grant_unc;

  // Winning bundle with the source's fixed AXI ID substituted.
  always_comb begin
    grant_aw    = grant_unc ? unc_aw : rep_aw;
    grant_aw.id = grant_unc ? UNC_ID : REP_ID;
  end

  // AW slot: holds the request stable until downstream accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
    end else if (load) begin
      slot_valid_q <= 1'b1;
      slot_q       <= grant_aw;
    end else if (aw_hs) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Round-robin pointer favours whichever source lost the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= SRC_REP;
    end else if (load) begin
      rr_q <= grant_unc ? SRC_REP : SRC_UNC;
    end
  end

  assign m_aw_valid = slot_valid_q;
  assign m_aw       = slot_q;

  // ---------------- W steering ----------------
  dcache_write_arbiter_w_order_fifo #(
    .DEPTH(ORDER_DEPTH)
  ) u_w_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (load),
    .push_src(grant_unc ? SRC_UNC : SRC_REP),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Only the source at the head of the order FIFO may drive W.
  always_comb begin
    m_w         = rep_w;
    m_w_valid   = 1'b0;
    rep_w_ready = 1'b0;
    unc_w_ready = 1'b0;
    if (!fifo_empty) begin
      if (fifo_head == SRC_UNC) begin
        m_w         = unc_w;
        m_w_valid   = unc_w_valid;
        unc_w_ready = m_w_ready;
      end else begin
        m_w         = rep_w;
        m_w_valid   = rep_w_valid;
        rep_w_ready = m_w_ready;
      end
    end
  end

  assign fifo_pop = m_w_valid && m_w_ready && m_w.last;

  // ---------------- B routing ----------------
  // Route by ID; responses with a foreign ID are swallowed and flagged.
  always_comb begin
    rep_b_valid = 1'b0;
    unc_b_valid = 1'b0;
    m_b_ready   = 1'b1;
    id_unknown  = 1'b0;
    if (m_b_id == REP_ID) begin
      rep_b_valid = m_b_valid;
      m_b_ready   = rep_b_ready;
    end else if (m_b_id == UNC_ID) begin
      unc_b_valid = m_b_valid;
      m_b_ready   = unc_b_ready;
    end else begin
      id_unknown  = 1'b1;
    end
  end

  assign rep_b_resp = m_b_resp;
  assign unc_b_resp = m_b_resp;
  assign b_hs       = m_b_valid && m_b_ready;

  // Sticky flag for responses carrying an ID this arbiter never issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_err_q <= 1'b0;
    end else if (m_b_valid && id_unknown) begin
      id_err_q <= 1'b1;
    end
  end

  assign id_err = id_err_q;

  // Outstanding writes: AW accepted downstream without a B yet; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q <= '0;
    end else if (aw_hs && !b_hs) begin
      out_cnt_q <= out_cnt_q + CntOne;
    end else if (!aw_hs && b_hs && (out_cnt_q != '0)) begin
      out_cnt_q <= out_cnt_q - CntOne;
    end
  end

  assign idle = !slot_valid_q && fifo_empty && (out_cnt_q == '0);

endmodule

// File: tb/tb_dcache_write_arbiter.sv
// Self-checking bench for dcache_write_arbiter: vector table plus directed sequences.
module tb_dcache_write_arbiter;
  import dcache_pkg::*;

  localparam logic [AXI_ID_W-1:0] RepId = DCACHE_ID;
  localparam logic [AXI_ID_W-1:0] UncId = DCACHE_ID + 6'd1;

  logic clk = 1'b0;
  logic rst;
  logic rep_aw_valid, rep_aw_ready, rep_w_valid, rep_w_ready, rep_b_valid, rep_b_ready;
  logic unc_aw_valid, unc_aw_ready, unc_w_valid, unc_w_ready, unc_b_valid, unc_b_ready;
  logic [1:0] rep_b_resp, unc_b_resp;
  AxiAwReq rep_aw, unc_aw, m_aw;
  AxiWBeat rep_w, unc_w, m_w;
  logic rep_urgent;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [AXI_ID_W-1:0] m_b_id;
  logic [1:0] m_b_resp;
  logic idle, id_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rep_aw_valid(rep_aw_valid),
    .rep_aw_ready(rep_aw_ready),
    .rep_aw      (rep_aw),
    .rep_w_valid (rep_w_valid),
    .rep_w_ready (rep_w_ready),
    .rep_w       (rep_w),
    .rep_b_valid (rep_b_valid),
    .rep_b_ready (rep_b_ready),
    .rep_b_resp  (rep_b_resp),
    .rep_urgent  (rep_urgent),
    .unc_aw_valid(unc_aw_valid),
    .unc_aw_ready(unc_aw_ready),
    .unc_aw      (unc_aw),
    .unc_w_valid (unc_w_valid),
    .unc_w_ready (unc_w_ready),
    .unc_w       (unc_w),
    .unc_b_valid (unc_b_valid),
    .unc_b_ready (unc_b_ready),
    .unc_b_resp  (unc_b_resp),
    .m_aw_valid  (m_aw_valid),
    .m_aw_ready  (m_aw_ready),
    .m_aw        (m_aw),
    .m_w_valid   (m_w_valid),
    .m_w_ready   (m_w_ready),
    .m_w         (m_w),
    .m_b_valid   (m_b_valid),
    .m_b_ready   (m_b_ready),
    .m_b_id      (m_b_id),
    .m_b_resp    (m_b_resp),
    .idle        (idle),
    .id_err      (id_err)
  );

  typedef struct {
    logic                do_rst;
    logic                rep_v;
    logic                unc_v;
    logic                urg;
    logic                mawr;
    logic                mbv;
    logic [AXI_ID_W-1:0] mbid;
    logic                brr;
    logic                bru;
    logic                exp_rep_rdy;
    logic                exp_unc_rdy;
    logic                exp_maw_v;
    logic [AXI_ID_W-1:0] exp_maw_id;
    logic                exp_idle;
    logic                exp_mbr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rv, logic uv, logic urg, logic mawr, logic mbv,
                              logic [AXI_ID_W-1:0] mbid, logic brr, logic bru, logic er,
                              logic eu, logic ev, logic [AXI_ID_W-1:0] eid, logic eidle,
                              logic embr);
    vec_t v;
    v.do_rst = r;  v.rep_v = rv; v.unc_v = uv; v.urg = urg; v.mawr = mawr; v.mbv = mbv;
    v.mbid = mbid; v.brr = brr; v.bru = bru; v.exp_rep_rdy = er; v.exp_unc_rdy = eu;
    v.exp_maw_v = ev; v.exp_maw_id = eid; v.exp_idle = eidle; v.exp_mbr = embr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    rep_aw_valid = 1'b0; rep_w_valid = 1'b0; rep_b_ready = 1'b0; rep_urgent = 1'b0;
    unc_aw_valid = 1'b0; unc_w_valid = 1'b0; unc_b_ready = 1'b0;
    rep_aw = '{addr: 32'h1000, len: 8'd7, size: 3'd3, id: 6'h15};
    unc_aw = '{addr: 32'h2000, len: 8'd0, size: 3'd3, id: 6'h00};
    rep_w = '{data: 64'h0, wstrb: 8'hFF, last: 1'b1};
    unc_w = '{data: 64'h55, wstrb: 8'h0F, last: 1'b1};
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_b_id = '0; m_b_resp = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;

    // rst rv uv urg mawr mbv mbid brr bru | rep_rdy unc_rdy maw_v maw_id idle m_b_ready
    // Alternation, outstanding limit and B routing.
    vecs.push_back(mk(1, 0,0,0,0, 0,6'd0, 0,0,  0,0,0,6'd0,0,0));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  1,0,0,6'd0,1,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,1,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  1,0,1,UncId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,1,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,0,1,UncId,0,1));
    vecs.push_back(mk(0, 0,0,0,1, 0,6'd0, 1,1,  0,0,0,6'd0,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 1,RepId, 0,1,  0,0,0,6'd0,0,0));
    vecs.push_back(mk(0, 1,1,0,1, 1,RepId, 1,1,  0,0,0,6'd0,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  1,0,0,6'd0,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,0,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,0,0,6'd0,0,1));
    vecs.push_back(mk(0, 0,0,0,1, 1,UncId, 0,1,  0,0,0,6'd0,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,1,0,6'd0,0,1));
    // Urgent replace priority, then alternation and AW valid-hold.
    vecs.push_back(mk(1, 0,0,0,0, 0,6'd0, 0,0,  0,0,0,6'd0,0,0));
    vecs.push_back(mk(0, 1,1,1,1, 0,6'd0, 1,1,  1,0,0,6'd0,1,1));
    vecs.push_back(mk(0, 1,1,1,1, 0,6'd0, 1,1,  1,0,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,1,1, 0,6'd0, 1,1,  1,0,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,1,1,RepId,0,1));
    vecs.push_back(mk(0, 1,1,0,0, 0,6'd0, 1,1,  0,0,1,UncId,0,1));
    vecs.push_back(mk(0, 1,1,0,0, 0,6'd0, 1,1,  0,0,1,UncId,0,1));
    vecs.push_back(mk(0, 1,1,0,1, 0,6'd0, 1,1,  0,0,1,UncId,0,1));

    // Single-beat W from both sources drains the order FIFO during the table.
    rep_w_valid = 1'b1; unc_w_valid = 1'b1; m_w_ready = 1'b1;
    foreach (vecs[i]) begin
      rst = vecs[i].do_rst;
      rep_aw_valid = vecs[i].rep_v; unc_aw_valid = vecs[i].unc_v; rep_urgent = vecs[i].urg;
      m_aw_ready = vecs[i].mawr; m_b_valid = vecs[i].mbv; m_b_id = vecs[i].mbid;
      rep_b_ready = vecs[i].brr; unc_b_ready = vecs[i].bru;
      #1;
      if (!vecs[i].do_rst) begin
        chk($sformatf("row%0d rep_aw_ready", i), 64'(rep_aw_ready), 64'(vecs[i].exp_rep_rdy));
        chk($sformatf("row%0d unc_aw_ready", i), 64'(unc_aw_ready), 64'(vecs[i].exp_unc_rdy));
        chk($sformatf("row%0d m_aw_valid", i), 64'(m_aw_valid), 64'(vecs[i].exp_maw_v));
        if (vecs[i].exp_maw_v)
          chk($sformatf("row%0d m_aw.id", i), 64'(m_aw.id), 64'(vecs[i].exp_maw_id));
        chk($sformatf("row%0d idle", i), 64'(idle), 64'(vecs[i].exp_idle));
        chk($sformatf("row%0d m_b_ready", i), 64'(m_b_ready), 64'(vecs[i].exp_mbr));
      end
      step();
    end

    // Replace line write: 8 beats, id forced, B back to replace source.
    clear_inputs();
    do_reset();
    #1;
    chk("reset idle", 64'(idle), 64'd1);
    chk("reset m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("reset id_err", 64'(id_err), 64'd0);
    rep_aw_valid = 1'b1;
    #1;
    chk("line rep_aw_ready", 64'(rep_aw_ready), 64'd1);
    chk("line m_aw_valid early", 64'(m_aw_valid), 64'd0);
    step();
    rep_aw_valid = 1'b0; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    #1;
    chk("line m_aw_valid", 64'(m_aw_valid), 64'd1);
    chk("line m_aw.id", 64'(m_aw.id), 64'(RepId));
    chk("line m_aw.addr", 64'(m_aw.addr), 64'h1000);
    chk("line m_aw.len", 64'(m_aw.len), 64'd7);
    for (int b = 0; b < 8; b++) begin
      rep_w_valid = 1'b1;
      rep_w.data = 64'hA0 + 64'(b);
      rep_w.last = (b == 7);
      #1;
      chk($sformatf("beat%0d m_w_valid", b), 64'(m_w_valid), 64'd1);
      chk($sformatf("beat%0d m_w.data", b), m_w.data, 64'hA0 + 64'(b));
      chk($sformatf("beat%0d rep_w_ready", b), 64'(rep_w_ready), 64'd1);
      chk($sformatf("beat%0d m_w.last", b), 64'(m_w.last), 64'(b == 7));
      step();
    end
    #1;
    chk("line fifo popped", 64'(m_w_valid), 64'd0);
    chk("line idle with B pending", 64'(idle), 64'd0);
    rep_w_valid = 1'b0;
    m_b_valid = 1'b1; m_b_id = RepId; m_b_resp = 2'b00; rep_b_ready = 1'b1;
    #1;
    chk("line rep_b_valid", 64'(rep_b_valid), 64'd1);
    chk("line rep_b_resp", 64'(rep_b_resp), 64'd0);
    chk("line unc_b_valid", 64'(unc_b_valid), 64'd0);
    chk("line m_b_ready", 64'(m_b_ready), 64'd1);
    step();
    m_b_valid = 1'b0;
    #1;
    chk("line idle after B", 64'(idle), 64'd1);

    // Order FIFO fills with W stalled; push+pop keeps occupancy.
    clear_inputs();
    do_reset();
    unc_aw_valid = 1'b1; m_aw_ready = 1'b1; unc_b_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_b_valid = (c >= 2); m_b_id = UncId;
      #1;
      chk($sformatf("fill grant%0d", c), 64'(unc_aw_ready), 64'd1);
      step();
    end
    #1;
    chk("fill 5th stalled", 64'(unc_aw_ready), 64'd0);
    step();
    m_b_valid = 1'b0;
    unc_w_valid = 1'b1; m_w_ready = 1'b1;
    #1;
    chk("full pop only no grant", 64'(unc_aw_ready), 64'd0);
    chk("full unc_w_ready", 64'(unc_w_ready), 64'd1);
    step();
    #1;
    chk("push+pop grant", 64'(unc_aw_ready), 64'd1);
    step();
    unc_w_valid = 1'b0; m_w_ready = 1'b0;
    #1;
    chk("refill grant", 64'(unc_aw_ready), 64'd1);
    step();
    #1;
    chk("refilled stalled", 64'(unc_aw_ready), 64'd0);

    // Unknown B ID is dropped and latched as an error.
    unc_aw_valid = 1'b0;
    m_b_valid = 1'b1; m_b_id = 6'h3F; rep_b_ready = 1'b0; unc_b_ready = 1'b0;
    #1;
    chk("unk m_b_ready", 64'(m_b_ready), 64'd1);
    chk("unk rep_b_valid", 64'(rep_b_valid), 64'd0);
    chk("unk unc_b_valid", 64'(unc_b_valid), 64'd0);
    chk("unk id_err before", 64'(id_err), 64'd0);
    step();
    m_b_valid = 1'b0;
    #1;
    chk("unk id_err set", 64'(id_err), 64'd1);
    step();
    chk("unk id_err sticky", 64'(id_err), 64'd1);

    // Reset with live state discards everything.
    unc_w_valid = 1'b1; m_w_ready = 1'b1;
    do_reset();
    #1;
    chk("rst id_err", 64'(id_err), 64'd0);
    chk("rst idle", 64'(idle), 64'd1);
    chk("rst m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst m_w_valid", 64'(m_w_valid), 64'd0);
    chk("rst unc_w_ready", 64'(unc_w_ready), 64'd0);
    chk("rst rep_aw_ready", 64'(rep_aw_ready), 64'd0);
    chk("rst unc_aw_ready", 64'(unc_aw_ready), 64'd0);
    chk("rst rep_b_valid", 64'(rep_b_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
